// File: rtl/irq_controller.sv
// Interrupt controller: rising-edge pending latch, software mask, priority select, irq/ack/EOI.
// Optional rotating priority when IRQC_ROUND_ROBIN_EN is defined.
module irq_controller #(
  parameter int unsigned NUM_SRC = 8,
  parameter logic [15:0] BASE    = 16'd980
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [15:0]        addr,
  input  logic               we,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               irq,
  output logic [2:0]         vec,
  input  logic               irq_ack,
  input  logic               eoi
);

  typedef enum logic [1:0] {StIdle, StReq, StSvc} state_e;

  // Internal registers are 8 wide; bits at or above NUM_SRC are forced to zero.
  localparam logic [7:0] ValidMask = 8'((9'd1 << NUM_SRC) - 9'd1);

  state_e      state_q;
  logic [7:0]  src_ext, src_q;
  logic [7:0]  pend_q, pend_d, mask_q, mask_d;
  logic [7:0]  pend_set, pend_clr, elig, vec_oh, stat;
  logic [15:0] offset;
  logic [1:0]  reg_sel;
  logic        hit, wr_pend, wr_mask, wr_cmd;
  logic        ack_take, eoi_any, req_live;
  logic [2:0]  sel, stat_rr;

  always_comb begin
    src_ext              = '0;
    src_ext[NUM_SRC-1:0] = src;
  end

  assign offset  = addr - BASE;
  assign hit     = (addr >= BASE) && (offset < 16'd4);
  assign reg_sel = offset[1:0];
  assign wr_pend = hit && we && (reg_sel == 2'd0);
  assign wr_mask = hit && we && (reg_sel == 2'd1);
  assign wr_cmd  = hit && we && (reg_sel == 2'd3);

  assign vec_oh   = 8'd1 << vec;
  assign ack_take = (state_q == StReq) && irq_ack;
  assign eoi_any  = eoi || (wr_cmd && din[0]);

  // Set beats clear: a fresh edge survives a same-cycle W1C or ack-clear.
  assign pend_set = src_ext & ~src_q;
  assign pend_clr = (wr_pend ? din : 8'd0) | (ack_take ? vec_oh : 8'd0);
  assign pend_d   = ((pend_q & ~pend_clr) | pend_set) & ValidMask;
  assign mask_d   = wr_mask ? (din & ValidMask) : mask_q;

  // Withdrawal looks at next-state PEND/MASK so irq drops on the same edge the write lands.
  assign req_live = |(pend_d & mask_d & vec_oh);
  assign elig     = pend_q & mask_q;

`ifdef IRQC_ROUND_ROBIN_EN
  logic [2:0] rr_q, rr_nxt;
  logic [3:0] vec_inc;

  always_comb begin
    logic [3:0] idx;
    logic       found;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = {1'b0, rr_q} + 4'(i);
      if (idx >= 4'(NUM_SRC)) idx = idx - 4'(NUM_SRC);
      if (!found && elig[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
  end

  assign vec_inc = {1'b0, vec} + 4'd1;
  assign rr_nxt  = (vec_inc >= 4'(NUM_SRC)) ? 3'd0 : vec_inc[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if ((state_q == StSvc) && eoi_any) begin
      rr_q <= rr_nxt;
    end
  end

  assign stat_rr = rr_q;
`else
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) sel = 3'(i);
    end
  end

  assign stat_rr = 3'd0;
`endif

  assign stat = {(state_q == StSvc), stat_rr, 1'b0, vec};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      src_q  <= src_ext;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      irq     <= 1'b0;
      vec     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|elig) begin
            state_q <= StReq;
            irq     <= 1'b1;
            vec     <= sel;
          end
        end
        StReq: begin
          if (irq_ack) begin
            state_q <= StSvc;
            irq     <= 1'b0;
          end else if (!req_live) begin
            state_q <= StIdle;
            irq     <= 1'b0;
          end
        end
        StSvc: begin
          if (eoi_any) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          irq     <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port; off-window addresses leave dout untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (hit) begin
      case (reg_sel)
        2'd0:    dout <= pend_q;
        2'd1:    dout <= mask_q;
        2'd2:    dout <= stat;
        default: dout <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; bus reads go through an expected-value queue.
module tb_irq_controller;

  localparam int unsigned NumSrc = 8;
  localparam logic [15:0] Base   = 16'd980;

`ifdef IRQC_ROUND_ROBIN_EN
  localparam logic [7:0] StatAfterEoiA = 8'h21;
`else
  localparam logic [7:0] StatAfterEoiA = 8'h01;
`endif

  logic              clk;
  logic              rst_n;
  logic [NumSrc-1:0] src;
  logic [15:0]       addr;
  logic              we;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              irq;
  logic [2:0]        vec;
  logic              irq_ack;
  logic              eoi;

  irq_controller #(
    .NUM_SRC (NumSrc),
    .BASE    (Base)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (src),
    .addr    (addr),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .irq     (irq),
    .vec     (vec),
    .irq_ack (irq_ack),
    .eoi     (eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic exp_irq, input logic [2:0] exp_vec);
    chk({tag, "_irq"}, {7'd0, irq}, {7'd0, exp_irq});
    chk({tag, "_vec"}, {5'd0, vec}, {5'd0, exp_vec});
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] data);
    addr = Base + {14'd0, off};
    we   = 1'b1;
    din  = data;
    @(negedge clk);
    we   = 1'b0;
    addr = 16'd0;
    din  = 8'd0;
  endtask

  task automatic rd(input logic [1:0] off, input logic [7:0] exp, input string tag);
    exp_t e;
    addr = Base + {14'd0, off};
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    addr = 16'd0;
    e = sb_q.pop_front();
    chk(e.tag, dout, e.exp);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    @(negedge clk);
    eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; src = '0; addr = 16'd0; we = 1'b0; din = 8'd0;
    irq_ack = 1'b0; eoi = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk_port("rst", 1'b0, 3'd0);
    chk("rst_dout", dout, 8'h00);
    rd(2'd0, 8'h00, "rst_pend");
    rd(2'd1, 8'h00, "rst_mask");
    rd(2'd2, 8'h00, "rst_stat");

    // Single source, full handshake with software EOI
    wr(2'd1, 8'h07);
    src = 8'h02;
    @(negedge clk);
    src = 8'h00;
    chk_port("a_lat1", 1'b0, 3'd0);
    rd(2'd0, 8'h02, "a_pend");
    chk_port("a_req", 1'b1, 3'd1);
    pulse_ack();
    chk_port("a_ack", 1'b0, 3'd1);
    rd(2'd0, 8'h00, "a_pend_clr");
    rd(2'd2, 8'h81, "a_stat_svc");
    wr(2'd3, 8'h01);
    rd(2'd2, StatAfterEoiA, "a_stat_idle");
    chk_port("a_idle", 1'b0, 3'd1);

    // Simultaneous edges: priority order, then next request two cycles after EOI
    wr(2'd1, 8'hFF);
    src = 8'h28;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk);
    chk_port("b_first", 1'b1, 3'd3);
    pulse_ack();
    pulse_eoi();
    chk_port("b_eoi", 1'b0, 3'd3);
    @(negedge clk);
    chk_port("b_second", 1'b1, 3'd5);
    pulse_ack();
    pulse_eoi();

    // Masked pending, enable, then withdraw by masking while in REQ
    wr(2'd1, 8'h00);
    src = 8'h04;
    @(negedge clk);
    src = 8'h00;
    rd(2'd0, 8'h04, "c_pend");
    chk_port("c_masked", 1'b0, 3'd5);
    wr(2'd1, 8'h04);
    chk_port("c_en_lat1", 1'b0, 3'd5);
    @(negedge clk);
    chk_port("c_req", 1'b1, 3'd2);
    wr(2'd1, 8'h00);
    chk_port("c_withdraw", 1'b0, 3'd2);
    rd(2'd0, 8'h04, "c_pend_kept");

    // Set beats W1C in the same cycle
    wr(2'd0, 8'h04);
    src = 8'h01;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk);
    src = 8'h01;
    wr(2'd0, 8'h01);
    src = 8'h00;
    rd(2'd0, 8'h01, "d_set_wins");
    wr(2'd0, 8'h01);
    rd(2'd0, 8'h00, "d_w1c");

    // Re-request of the in-service source waits for EOI
    wr(2'd1, 8'h01);
    src = 8'h01;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk);
    chk_port("e_req", 1'b1, 3'd0);
    pulse_ack();
    src = 8'h01;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk);
    chk_port("e_svc_hold", 1'b0, 3'd0);
    rd(2'd0, 8'h01, "e_pend");
    chk_port("e_svc_hold2", 1'b0, 3'd0);
    pulse_eoi();
    chk_port("e_eoi", 1'b0, 3'd0);
    @(negedge clk);
    chk_port("e_rereq", 1'b1, 3'd0);

    // Reset during REQ
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_port("f_rst", 1'b0, 3'd0);
    chk("f_rst_dout", dout, 8'h00);
    rd(2'd0, 8'h00, "f_pend");
    rd(2'd1, 8'h00, "f_mask");

    // Off-window accesses leave dout and registers alone
    wr(2'd1, 8'h5A);
    rd(2'd1, 8'h5A, "g_mask");
    addr = 16'd979;
    @(negedge clk);
    addr = 16'd0;
    chk("g_dout_979", dout, 8'h5A);
    addr = 16'd979; we = 1'b1; din = 8'hFF;
    @(negedge clk);
    we = 1'b0; addr = 16'd0; din = 8'd0;
    rd(2'd1, 8'h5A, "g_mask_kept");

    // Line held high through reset registers one edge afterwards
    rst_n = 1'b0;
    src   = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    src = 8'h00;
    rd(2'd0, 8'h01, "h_pend");
    chk_port("h_masked", 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
